teleprinter_encoder: RTL and testbench

- Upstream feeder for the teleprinter-output UART transmitter.
- Accepts EDSAC 5-bit teleprinter codes from the machine's output order and tracks letter/figure shift state.
- Translates each code to an 8-bit ASCII byte and buffers bytes in a small FIFO.
- Presents bytes to the UART TX stage over a valid/ready handshake, all in the slow UART clock domain.

---
 rtl/teleprinter_pkg.sv | 50 +++++
 rtl/teleprinter_encoder_fifo.sv | 69 ++++++
 rtl/teleprinter_encoder.sv | 109 ++++++++++
 tb/tb_teleprinter_encoder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/teleprinter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | teleprinter_pkg: EDSAC teleprinter code constants, ASCII tables, FSM  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package teleprinter_pkg;

  localparam logic [4:0] CODE_FIGS  = 5'd11;
  localparam logic [4:0] CODE_LETS  = 5'd15;
  localparam logic [4:0] CODE_BLANK = 5'd16;
  localparam logic [4:0] CODE_CR    = 5'd18;
  localparam logic [4:0] CODE_SP    = 5'd20;
  localparam logic [4:0] CODE_LF    = 5'd24;

`ifdef TELEPRINTER_CRLF_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd1, ST_EMIT2 = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EMIT = 2'd1} state_e;
`endif

  localparam logic [7:0] LET_TABLE [32] = '{
    8'h50, 8'h51, 8'h57, 8'h45, 8'h52, 8'h54, 8'h59, 8'h55,
    8'h49, 8'h4F, 8'h4A, 8'h23, 8'h53, 8'h5A, 8'h4B, 8'h2A,
    8'h2E, 8'h46, 8'h40, 8'h44, 8'h21, 8'h48, 8'h4E, 8'h4D,
    8'h26, 8'h4C, 8'h58, 8'h47, 8'h41, 8'h42, 8'h43, 8'h56
  };

  // Codes with no figure glyph (J, H) keep their letter-shift ASCII.
  localparam logic [7:0] FIG_TABLE [32] = '{
    8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
    8'h38, 8'h39, 8'h4A, 8'h23, 8'h22, 8'h2B, 8'h28, 8'h2A,
    8'h2E, 8'h24, 8'h40, 8'h3B, 8'h21, 8'h48, 8'h2C, 8'h2E,
    8'h26, 8'h29, 8'h2F, 8'h23, 8'h2D, 8'h3F, 8'h3A, 8'h3D
  };

  function automatic logic [7:0] decode_byte(input logic [4:0] code, input logic fig);
    logic [7:0] b;
    if (fig) b = FIG_TABLE[code];
    else     b = LET_TABLE[code];
    case (code)
      CODE_CR: b = 8'h0D;
      CODE_LF: b = 8'h0A;
      CODE_SP: b = 8'h20;
      default: ;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/teleprinter_encoder_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tp_byte_fifo: circular byte FIFO with fill count and sticky overflow |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tp_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [CNT_W-1:0] fill,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  logic             ovf_q, ovf_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (fill_q != FULL_CNT);
    do_rd    = rd_ready && (fill_q != '0);
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    fill_d   = fill_q;
    case ({do_wr, do_rd})
      2'b10:   fill_d = fill_q + CNT_W'(1);
      2'b01:   fill_d = fill_q - CNT_W'(1);
      default: ;
    endcase
    ovf_d    = ovf_q | (wr_en && (fill_q == FULL_CNT));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; the read side is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = (fill_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fill     = fill_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: rtl/teleprinter_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | teleprinter_encoder: EDSAC 5-bit codes -> ASCII bytes for UART TX     |
// | Option macro TELEPRINTER_CRLF_EN: code 18 emits CR followed by LF.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module teleprinter_encoder
  import teleprinter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fig_mode,
  output logic [CNT_W-1:0] fill,
  output logic             overflow
);

  // Two free entries guarantee room for a CR+LF pair after acceptance.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);

  state_e     state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic       fig_q, fig_d;
  logic       live_q, live_d;
  logic       wr_en;
  logic [7:0] wr_data;

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    fig_d    = fig_q;
    live_d   = 1'b1;
    wr_en    = 1'b0;
    wr_data  = byte_q;
    in_ready = (state_q == ST_IDLE) && live_q && (fill <= READY_MAX);
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          case (in_code)
            CODE_FIGS:  fig_d = 1'b1;
            CODE_LETS:  fig_d = 1'b0;
            CODE_BLANK: ;
            default: begin
              byte_d  = decode_byte(in_code, fig_q);
              state_d = ST_EMIT;
            end
          endcase
        end
      end
      ST_EMIT: begin
        wr_en = 1'b1;
`ifdef TELEPRINTER_CRLF_EN
        state_d = (byte_q == 8'h0D) ? ST_EMIT2 : ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
`ifdef TELEPRINTER_CRLF_EN
      ST_EMIT2: begin
        wr_en   = 1'b1;
        wr_data = 8'h0A;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      byte_q  <= 8'h00;
      fig_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      fig_q   <= fig_d;
      live_q  <= live_d;
    end
  end

  tp_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_ready (out_ready),
    .rd_data  (out_byte),
    .rd_valid (out_valid),
    .fill     (fill),
    .overflow (overflow)
  );

  assign fig_mode = fig_q;

endmodule
`default_nettype wire

// File: tb/tb_teleprinter_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_teleprinter_encoder: scoreboard bench for teleprinter_encoder      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_teleprinter_encoder;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    in_code;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          fig_mode;
  logic [CW-1:0] fill;
  logic          overflow;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];

  teleprinter_encoder #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fig_mode  (fig_mode),
    .fill      (fill),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pops the scoreboard whenever the DUT hands a byte over.
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(out_byte), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", 32'(out_byte), 32'(e));
        end
      end
    end
  endtask

  task automatic send(input logic [4:0] c);
    int t = 0;
    in_code  = c;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      tick(1);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 32'(in_ready), 32'd1);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick(1);
      t++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
    tick(2);
    check("drained_valid", 32'(out_valid), 32'd0);
    check("drained_fill", 32'(fill), 32'd0);
  endtask

  initial begin
    logic [7:0] held;
    int         sent;
    logic [4:0] stream_codes [4];
    logic [7:0] stream_bytes [4];
    stream_codes = '{5'd28, 5'd29, 5'd30, 5'd31};
    stream_bytes = '{8'h41, 8'h42, 8'h43, 8'h56};

    reset_n   = 1'b0;
    in_code   = 5'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fork
      monitor();
    join_none

    tick(3);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'h00);
    check("rst_fig_mode", 32'(fig_mode), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check("in_ready_before_clk", 32'(in_ready), 32'd0);
    tick(1);
    check("in_ready_after_clk", 32'(in_ready), 32'd1);

    // Letters A, B, C
    out_ready = 1'b1;
    exp_q.push_back(8'h41); send(5'd28);
    exp_q.push_back(8'h42); send(5'd29);
    exp_q.push_back(8'h43); send(5'd30);
    drain();
    check("fig_after_letters", 32'(fig_mode), 32'd0);

    // Figure shift, digits, letter shift
    send(5'd11);
    check("fig_after_figs", 32'(fig_mode), 32'd1);
    exp_q.push_back(8'h31); send(5'd1);
    exp_q.push_back(8'h32); send(5'd2);
    send(5'd15);
    check("fig_after_lets", 32'(fig_mode), 32'd0);
    exp_q.push_back(8'h51); send(5'd1);
    drain();

    // CR, blank, space, LF
    exp_q.push_back(8'h0D);
`ifdef TELEPRINTER_CRLF_EN
    exp_q.push_back(8'h0A);
`endif
    send(5'd18);
    send(5'd16);
    exp_q.push_back(8'h20); send(5'd20);
    exp_q.push_back(8'h0A); send(5'd24);
    drain();

    // Back-pressure until in_ready drops, then drain across the pointer wrap
    out_ready = 1'b0;
    sent = 0;
    for (int k = 0; k < 2 * DEPTH; k++) begin
      tick(2);
      if (!in_ready) break;
      exp_q.push_back(stream_bytes[k % 4]);
      send(stream_codes[k % 4]);
      sent++;
    end
    tick(2);
    check("stream_sent", 32'(sent), 32'(DEPTH - 1));
    check("stream_fill", 32'(fill), 32'(DEPTH - 1));
    check("stream_overflow", 32'(overflow), 32'd0);
    check("stream_valid", 32'(out_valid), 32'd1);
    held = out_byte;
    tick(3);
    check("hold_stable", 32'(out_byte), 32'(held));
    check("hold_head", 32'(out_byte), 32'h41);
    out_ready = 1'b1;
    drain();
    check("post_stream_overflow", 32'(overflow), 32'd0);

    // Simultaneous write and read at fill 3
    out_ready = 1'b0;
    exp_q.push_back(8'h41); send(5'd28);
    exp_q.push_back(8'h42); send(5'd29);
    exp_q.push_back(8'h43); send(5'd30);
    tick(1);
    check("fill_three", 32'(fill), 32'd3);
    exp_q.push_back(8'h56); send(5'd31);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("fill_simul_rw", 32'(fill), 32'd3);
    out_ready = 1'b1;
    drain();

    // Reset mid-stream with figure shift active and four bytes queued
    out_ready = 1'b0;
    send(5'd11);
    send(5'd5);
    send(5'd6);
    send(5'd7);
    send(5'd8);
    tick(1);
    check("pre_rst_fill", 32'(fill), 32'd4);
    check("pre_rst_fig", 32'(fig_mode), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_fill", 32'(fill), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fig", 32'(fig_mode), 32'd0);
    check("mid_rst_byte", 32'(out_byte), 32'h00);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    out_ready = 1'b1;
    exp_q.push_back(8'h50); send(5'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
